fp_compare_pipe: RTL

- Parametrised, pipelined floating-point comparator for the ray/AABB slab datapath. Operands use the FloPoCo encoding: 2-bit exception, sign, wE exponent, wF fraction.
- Compares operands directly, with no subtractor. Supports LT/LE/EQ/GE/GT predicates plus MIN/MAX selection, with NaN/unordered reporting.
- Uses valid/ready handshakes and carries a sideband tag, so it can sit in the t-near/t-far reduction tree.

---
 rtl/fp_compare_pipe.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fp_compare_pipe.sv
// Pipelined FloPoCo-format comparator: predicates, MIN/MAX selection and NaN reporting
// behind a valid/ready handshake with a global stall and a sideband tag.
module fp_compare_pipe #(
    parameter int WE   = 11,
    parameter int WF   = 16,
    parameter int LAT  = 2,
    parameter int TAGW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WE+WF+2:0]     in_a,
    input  logic [WE+WF+2:0]     in_b,
    input  logic [TAGW-1:0]      in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 flag,
    output logic                 unordered,
    output logic [WE+WF+2:0]     result,
    output logic [TAGW-1:0]      out_tag
);
    localparam int W = WE + WF + 3;

    typedef struct packed {
        logic            nan_a;
        logic            nan_b;
        logic            lt;
        logic            eq;
        logic [2:0]      op;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [TAGW-1:0] tag;
    } cmp_t;

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Coarse ordering class: -inf, -normal, zero, +normal, +inf (NaN rank is don't-care).
    function automatic logic [2:0] rank(input logic [1:0] exn, input logic sign);
        case (exn)
            2'b00:   rank = 3'd2;
            2'b01:   rank = sign ? 3'd1 : 3'd3;
            default: rank = sign ? 3'd0 : 3'd4;
        endcase
    endfunction

    logic [1:0]       exn_a, exn_b;
    logic             sign_a, sign_b;
    logic [WE+WF-1:0] mag_a, mag_b;
    logic [2:0]       rank_a, rank_b;
    logic             mag_lt, mag_eq, same_rank;
    cmp_t             cmp;

    assign exn_a     = in_a[W-1 -: 2];
    assign exn_b     = in_b[W-1 -: 2];
    assign sign_a    = in_a[W-3];
    assign sign_b    = in_b[W-3];
    assign mag_a     = in_a[WE+WF-1:0];
    assign mag_b     = in_b[WE+WF-1:0];
    assign rank_a    = rank(exn_a, sign_a);
    assign rank_b    = rank(exn_b, sign_b);
    assign mag_lt    = mag_a < mag_b;
    assign mag_eq    = mag_a == mag_b;
    assign same_rank = rank_a == rank_b;

    // Only normals need the magnitude; equal rank implies both are normal with equal sign.
    always_comb begin
        cmp       = '0;
        cmp.nan_a = exn_a == 2'b11;
        cmp.nan_b = exn_b == 2'b11;
        cmp.lt    = (rank_a < rank_b) ||
                    (same_rank && exn_a == 2'b01 && (sign_a ? (!mag_lt && !mag_eq) : mag_lt));
        cmp.eq    = same_rank && (exn_a != 2'b01 || mag_eq);
        cmp.op    = op;
        cmp.a     = in_a;
        cmp.b     = in_b;
        cmp.tag   = in_tag;
    end

    cmp_t fin;

    generate
        if (LAT == 1) begin : g_direct
            assign fin = cmp;
        end else begin : g_pipe
            cmp_t st [LAT-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT-1; i++) st[i] <= '0;
                end else if (advance) begin
                    st[0] <= cmp;
                    for (int i = 1; i < LAT-1; i++) st[i] <= st[i-1];
                end
            end
            assign fin = st[LAT-2];
        end
    endgenerate

    logic [LAT:1] vld_pipe;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (advance) begin
            vld_pipe[1] <= in_valid;
            for (int k = 2; k <= LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end
    assign out_valid = vld_pipe[LAT];

    logic         unord, nan_only_a, sel_b, nxt_flag;
    logic [W-1:0] nxt_result;

    always_comb begin
        unord      = fin.nan_a || fin.nan_b;
        nan_only_a = fin.nan_a && !fin.nan_b;
        sel_b      = 1'b0;
        nxt_flag   = 1'b0;
        case (fin.op)
            3'b001: nxt_flag = !unord && (fin.lt || fin.eq);
            3'b010: nxt_flag = !unord && fin.eq;
            3'b011: nxt_flag = !unord && !fin.lt;
            3'b100: nxt_flag = !unord && !fin.lt && !fin.eq;
            // A NaN loses to any number; two NaNs or a tie keep A.
            3'b101: begin
                sel_b    = nan_only_a || (!unord && !fin.lt && !fin.eq);
                nxt_flag = sel_b;
            end
            3'b110: begin
                sel_b    = nan_only_a || (!unord && fin.lt);
                nxt_flag = sel_b;
            end
            default: nxt_flag = !unord && fin.lt;
        endcase
        nxt_result = sel_b ? fin.b : fin.a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag      <= 1'b0;
            unordered <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            flag      <= nxt_flag;
            unordered <= unord;
            result    <= nxt_result;
            out_tag   <= fin.tag;
        end
    end
endmodule
